// File: rtl/vga_image_clear_if.sv
// vga_image_clear_if: pixel-write bus between the AHB image-write path,
// the clear stage and the image RAM (upstream in_* and downstream ram_*).
interface vga_image_clear_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 8
);

  logic                  in_we;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic [DATA_WIDTH-1:0] in_wdata;
  logic                  in_ready;

  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;

  modport master (
    output in_we,
    output in_addr,
    output in_wdata,
    input  in_ready,
    input  ram_we,
    input  ram_addr,
    input  ram_wdata
  );

  modport slave (
    input  in_we,
    input  in_addr,
    input  in_wdata,
    output in_ready,
    output ram_we,
    output ram_addr,
    output ram_wdata
  );

endinterface

// File: rtl/vga_image_clear.sv
// vga_image_clear: fills the image RAM with CLEAR_VALUE after reset, then
// forwards pixel writes with one registered cycle. VGA_CLR_REQ_EN adds clr_req_i.
module vga_image_clear #(
  parameter int                   ADDR_WIDTH  = 15,
  parameter int                   DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                clk,
  input  logic                rst,
`ifdef VGA_CLR_REQ_EN
  input  logic                clr_req_i,
`endif
  vga_image_clear_if.slave    bus,
  output logic                clr_busy_o,
  output logic                clr_done_o
);

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_PASS  = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] CNT_TOP = '1;

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
  logic                  busy_q, busy_d;
  logic                  ready_q, ready_d;
  logic                  done_q, done_d;

  // Next-state: sweep the address space, then hand the RAM to upstream.
  // The first PASS cycle (still busy) raises ready and pulses done.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    ready_d     = ready_q;
    done_d      = 1'b0;
    ram_we_d    = bus.in_we & ready_q;
    ram_addr_d  = bus.in_addr;
    ram_wdata_d = bus.in_wdata;
    unique case (state_q)
      S_CLEAR: begin
        ram_we_d    = 1'b1;
        ram_addr_d  = cnt_q;
        ram_wdata_d = CLEAR_VALUE;
        cnt_d       = cnt_q + 1'b1;
        if (cnt_q == CNT_TOP) begin
          state_d = S_PASS;
        end
      end
      S_PASS: begin
        if (busy_q) begin
          busy_d  = 1'b0;
          ready_d = 1'b1;
          done_d  = 1'b1;
        end
`ifdef VGA_CLR_REQ_EN
        if (clr_req_i) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
          busy_d  = 1'b1;
          ready_d = 1'b0;
          done_d  = 1'b0;
        end
`endif
      end
      default: begin
        state_d = S_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // State and registered RAM-side outputs; reset restarts the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_CLEAR;
      cnt_q       <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      busy_q      <= 1'b1;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
    end
  end

  assign bus.in_ready  = ready_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign clr_busy_o    = busy_q;
  assign clr_done_o    = done_q;

endmodule
